// File: rtl/alu_lcd_pkg.sv
// alu_lcd_pkg: shared capture-state encoding, display slot indices and the
// 5-character ASCII slot names used by the ALU LCD demo controller.
package alu_lcd_pkg;

  // Capture state; the raw encoding is shown on the board LEDs.
  typedef enum logic [1:0] {
    S_SRC1 = 2'd0,
    S_SRC2 = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } cap_state_t;

  // Display slot indices requested by the LCD driver.
  localparam logic [5:0] SLOT_SRC1  = 6'd1;
  localparam logic [5:0] SLOT_SRC2  = 6'd2;
  localparam logic [5:0] SLOT_ALUOP = 6'd3;
  localparam logic [5:0] SLOT_RESLT = 6'd4;
  localparam logic [5:0] SLOT_STATE = 6'd5;
  localparam logic [5:0] SLOT_INCNT = 6'd6;

  // Slot names, first character in the most significant byte.
  localparam logic [39:0] NAME_SRC1  = 40'h5352435F31; // "SRC_1"
  localparam logic [39:0] NAME_SRC2  = 40'h5352435F32; // "SRC_2"
  localparam logic [39:0] NAME_ALUOP = 40'h414C554F50; // "ALUOP"
  localparam logic [39:0] NAME_RESLT = 40'h5245534C54; // "RESLT"
  localparam logic [39:0] NAME_STATE = 40'h5354415445; // "STATE"
  localparam logic [39:0] NAME_INCNT = 40'h494E434E54; // "INCNT"

endpackage

// File: rtl/alu_lcd_ctrl_edge.sv
// lcd_input_edge: one-cycle registered rising-edge detector for a strobe that
// may stay high for many cycles. A level already high while reset is asserted
// is not treated as an edge after reset is released; it must drop first.
module lcd_input_edge (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic pulse_out
);

  logic level_d_r;   // level_in delayed by one cycle
  logic blocked_r;   // level was high during reset and has not dropped since

  // Delay register for edge detection, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level_in;
    end
  end

  // Suppress the edge of a level that was already high across reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      blocked_r <= level_in;
    end else begin
      blocked_r <= blocked_r & level_in;
    end
  end

  assign pulse_out = level_in & ~level_d_r & ~blocked_r;

endmodule

// File: rtl/alu_lcd_ctrl.sv
// alu_lcd_ctrl: captures touch-screen entries as ALU operand 1, operand 2 and
// opcode, registers the ALU result, and answers the LCD driver's slot scan
// with a name/value pair one cycle after the slot index is presented.
// Optional build macro ALU_LCD_INPUT_CNT_EN adds an accepted-entry counter
// shown in slot 6 ("INCNT").
module alu_lcd_ctrl
  import alu_lcd_pkg::*;
#(
  parameter int ALU_OP_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          display_number,
  output logic                display_valid,
  output logic [39:0]         display_name,
  output logic [31:0]         display_value,
  input  logic                input_valid,
  input  logic [31:0]         input_value,
  output logic [31:0]         alu_src1,
  output logic [31:0]         alu_src2,
  output logic [ALU_OP_W-1:0] alu_control,
  input  logic [31:0]         alu_result,
  output logic [1:0]          busy_state
);

  cap_state_t  state_r;
  logic [31:0] result_r;
  logic        entry_pulse;
  logic [31:0] control_ext;

  lcd_input_edge u_input_edge (
    .clk       (clk),
    .reset     (reset),
    .level_in  (input_valid),
    .pulse_out (entry_pulse)
  );

  assign busy_state = state_r;

  // Zero-extend the opcode for display; written bitwise so ALU_OP_W=32 works.
  always_comb begin
    control_ext = 32'd0;
    control_ext[ALU_OP_W-1:0] = alu_control;
  end

  // Capture FSM: one register loaded per accepted entry, result tracks the ALU in S_DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_SRC1;
      alu_src1    <= 32'd0;
      alu_src2    <= 32'd0;
      alu_control <= {ALU_OP_W{1'b0}};
      result_r    <= 32'd0;
    end else begin
      if (state_r == S_DONE) begin
        result_r <= alu_result;
      end
      if (entry_pulse) begin
        case (state_r)
          S_SRC1: begin
            alu_src1 <= input_value;
            state_r  <= S_SRC2;
          end
          S_SRC2: begin
            alu_src2 <= input_value;
            state_r  <= S_OP;
          end
          S_OP: begin
            alu_control <= input_value[ALU_OP_W-1:0];
            state_r     <= S_DONE;
          end
          S_DONE: begin
            // New round: only operand 1 is replaced now.
            alu_src1 <= input_value;
            state_r  <= S_SRC2;
          end
          default: begin
            state_r <= S_SRC1;
          end
        endcase
      end
    end
  end

`ifdef ALU_LCD_INPUT_CNT_EN
  logic [31:0] in_cnt_r;

  // Count accepted entries; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_r <= 32'd0;
    end else if (entry_pulse) begin
      in_cnt_r <= in_cnt_r + 32'd1;
    end else begin
      in_cnt_r <= in_cnt_r;
    end
  end
`endif

  // Registered slot lookup: outputs reflect the index and registers of the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_valid <= 1'b0;
      display_name  <= 40'd0;
      display_value <= 32'd0;
    end else begin
      case (display_number)
        SLOT_SRC1: begin
          display_valid <= 1'b1;
          display_name  <= NAME_SRC1;
          display_value <= alu_src1;
        end
        SLOT_SRC2: begin
          display_valid <= 1'b1;
          display_name  <= NAME_SRC2;
          display_value <= alu_src2;
        end
        SLOT_ALUOP: begin
          display_valid <= 1'b1;
          display_name  <= NAME_ALUOP;
          display_value <= control_ext;
        end
        SLOT_RESLT: begin
          display_valid <= 1'b1;
          display_name  <= NAME_RESLT;
          display_value <= result_r;
        end
        SLOT_STATE: begin
          display_valid <= 1'b1;
          display_name  <= NAME_STATE;
          display_value <= {30'd0, state_r};
        end
`ifdef ALU_LCD_INPUT_CNT_EN
        SLOT_INCNT: begin
          display_valid <= 1'b1;
          display_name  <= NAME_INCNT;
          display_value <= in_cnt_r;
        end
`endif
        default: begin
          display_valid <= 1'b0;
          display_name  <= 40'd0;
          display_value <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_lcd_ctrl.sv
// tb_alu_lcd_ctrl: directed self-checking bench for alu_lcd_ctrl with an
// adder standing in for the external ALU.
module tb_alu_lcd_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        input_valid;
  logic [31:0] input_value;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [11:0] alu_control;
  logic [31:0] alu_result;
  logic [1:0]  busy_state;

  int checks;
  int errors;
  int exp_cnt;

  alu_lcd_ctrl #(.ALU_OP_W(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .display_number (display_number),
    .display_valid  (display_valid),
    .display_name   (display_name),
    .display_value  (display_value),
    .input_valid    (input_valid),
    .input_value    (input_value),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .alu_control    (alu_control),
    .alu_result     (alu_result),
    .busy_state     (busy_state)
  );

  // ALU stand-in: add.
  assign alu_result = alu_src1 + alu_src2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted entry: rising edge for one cycle, then drop.
  task automatic entry(input logic [31:0] v);
    input_valid = 1'b1;
    input_value = v;
    tick();
    input_valid = 1'b0;
    tick();
    exp_cnt++;
  endtask

  task automatic check_display(input string tag, input logic v, input logic [39:0] n, input logic [31:0] val);
    check({tag, "_valid"}, {63'd0, display_valid}, {63'd0, v});
    check({tag, "_name"}, {24'd0, display_name}, {24'd0, n});
    check({tag, "_value"}, {32'd0, display_value}, {32'd0, val});
  endtask

  initial begin
    logic [39:0] en;
    logic [31:0] ev;
    logic        evld;
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    reset = 1'b1;
    input_valid = 1'b1;
    input_value = 32'h0000_0055;
    display_number = 6'd0;

    // Reset held 3 cycles with input_valid high.
    repeat (3) tick();
    check("rst_src1", {32'd0, alu_src1}, 64'd0);
    check("rst_src2", {32'd0, alu_src2}, 64'd0);
    check("rst_ctrl", {52'd0, alu_control}, 64'd0);
    check("rst_busy", {62'd0, busy_state}, 64'd0);
    check_display("rst_disp", 1'b0, 40'd0, 32'd0);

    // Release with input_valid still high: no capture.
    reset = 1'b0;
    repeat (3) tick();
    check("rel_busy", {62'd0, busy_state}, 64'd0);
    check("rel_src1", {32'd0, alu_src1}, 64'd0);
    input_valid = 1'b0;
    tick();

    // Operand 1, operand 2, opcode.
    entry(32'h1234_5678);
    check("e1_busy", {62'd0, busy_state}, 64'd1);
    check("e1_src1", {32'd0, alu_src1}, 64'h1234_5678);
    entry(32'h0000_0001);
    check("e2_busy", {62'd0, busy_state}, 64'd2);
    check("e2_src2", {32'd0, alu_src2}, 64'h0000_0001);
    display_number = 6'd4;
    tick();
    check_display("pre_res", 1'b1, 40'h5245534C54, 32'd0);
    entry(32'h0000_0001);
    check("e3_busy", {62'd0, busy_state}, 64'd3);
    check("e3_ctrl", {52'd0, alu_control}, 64'h001);
    tick();
    check_display("res", 1'b1, 40'h5245534C54, 32'h1234_5679);
    display_number = 6'd3;
    tick();
    check_display("aluop", 1'b1, 40'h414C554F50, 32'h0000_0001);

    // New round from S_DONE replaces only operand 1.
    entry(32'h0000_0010);
    check("nr_busy", {62'd0, busy_state}, 64'd1);
    check("nr_src1", {32'd0, alu_src1}, 64'h0000_0010);
    check("nr_src2", {32'd0, alu_src2}, 64'h0000_0001);
    check("nr_ctrl", {52'd0, alu_control}, 64'h001);

    // Long strobe in S_SRC1 captures once.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    tick();
    input_valid = 1'b1;
    input_value = 32'hAAAA_0000;
    repeat (50) tick();
    exp_cnt++;
    check("hold_src1", {32'd0, alu_src1}, 64'hAAAA_0000);
    check("hold_busy", {62'd0, busy_state}, 64'd1);
    check("hold_src2", {32'd0, alu_src2}, 64'd0);
    input_valid = 1'b0;
    tick();

    // Slot sweep; index changes every cycle so each check pins 1-cycle latency.
    for (int i = 0; i < 64; i++) begin
      display_number = i[5:0];
      tick();
      evld = 1'b1;
      case (i)
        1: begin en = 40'h5352435F31; ev = 32'hAAAA_0000; end
        2: begin en = 40'h5352435F32; ev = 32'd0; end
        3: begin en = 40'h414C554F50; ev = 32'd0; end
        4: begin en = 40'h5245534C54; ev = 32'd0; end
        5: begin en = 40'h5354415445; ev = 32'd1; end
`ifdef ALU_LCD_INPUT_CNT_EN
        6: begin en = 40'h494E434E54; ev = exp_cnt; end
`endif
        default: begin evld = 1'b0; en = 40'd0; ev = 32'd0; end
      endcase
      check($sformatf("sweep%0d", i), {24'd0, display_valid, display_name},
            {24'd0, evld, en});
      check($sformatf("sweepv%0d", i), {32'd0, display_value}, {32'd0, ev});
    end

    // Reset coinciding with an edge in S_OP wins.
    entry(32'h0000_0005);
    check("op_busy", {62'd0, busy_state}, 64'd2);
    reset = 1'b1;
    input_valid = 1'b1;
    input_value = 32'h0000_0003;
    tick();
    reset = 1'b0;
    input_valid = 1'b0;
    exp_cnt = 0;
    check("rop_ctrl", {52'd0, alu_control}, 64'd0);
    check("rop_busy", {62'd0, busy_state}, 64'd0);
    check("rop_src1", {32'd0, alu_src1}, 64'd0);
    check("rop_src2", {32'd0, alu_src2}, 64'd0);
    check_display("rop_disp", 1'b0, 40'd0, 32'd0);
    tick();

    // Slot 6.
`ifdef ALU_LCD_INPUT_CNT_EN
    force dut.in_cnt_r = 32'hFFFF_FFFE;
    tick();
    release dut.in_cnt_r;
    entry(32'h0000_0007);
    entry(32'h0000_0008);
    display_number = 6'd6;
    tick();
    check_display("incnt", 1'b1, 40'h494E434E54, 32'd0);
`else
    display_number = 6'd6;
    tick();
    check_display("slot6", 1'b0, 40'd0, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
